latency_fifo: RTL and testbench

//  Elastic buffer stage that sits directly downstream of each switch output port and feeds the next switch input.

---
 rtl/cicero_net_pkg.sv | 21 ++
 rtl/latency_fifo.sv | 86 ++++++++
 tb/tb_latency_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cicero_net_pkg.sv
// Shared network definitions: latency type, its ceiling and the saturating
// adder used by both the latency FIFO and the switch's min-latency compare.
package cicero_net_pkg;

    localparam int LAT_W = 5;

    typedef logic [LAT_W-1:0] latency_t;

    localparam latency_t LAT_MAX = '1;

    // Add two latencies one bit wider than the operands, then clamp to all-ones.
    function automatic latency_t sat_add_lat(input latency_t a, input latency_t b);
        logic [LAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, LAT_MAX}) begin
            return LAT_MAX;
        end
        return sum[LAT_W-1:0];
    endfunction

endpackage

// File: rtl/latency_fifo.sv
// Elastic ready/valid buffer placed after a switch output port. Reports its
// own occupancy plus the downstream switch's latency back upstream so the
// upstream switch can steer traffic to the least-loaded path.
module latency_fifo
    import cicero_net_pkg::*;
#(
    parameter int DWIDTH              = 16,
    parameter int LATENCY_COUNT_WIDTH = 5,
    parameter int DEPTH               = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [DWIDTH-1:0]              in_data,
    output logic                           in_ready,
    output logic [LATENCY_COUNT_WIDTH-1:0] in_latency,
    output logic                           out_valid,
    output logic [DWIDTH-1:0]              out_data,
    input  logic                           out_ready,
    input  logic [LATENCY_COUNT_WIDTH-1:0] out_latency
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("latency_fifo: DEPTH must be a power of two and at least 2");
    end
    if (CNT_W > LATENCY_COUNT_WIDTH) begin : g_chk_cnt_w
        $error("latency_fifo: occupancy count does not fit in the latency width");
    end
    // The latency type and saturating adder are shared with the switch, so the
    // port width has to match the package width.
    if (LATENCY_COUNT_WIDTH != LAT_W) begin : g_chk_lat_w
        $error("latency_fifo: LATENCY_COUNT_WIDTH must equal cicero_net_pkg::LAT_W");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    // Ready/valid derive only from registered occupancy: no path from out_ready to in_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Post-edge occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage, pointers, occupancy and the registered latency report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_latency <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            in_latency <= sat_add_lat(latency_t'(count_next), out_latency);
        end
    end

endmodule

// File: tb/tb_latency_fifo.sv
// Directed and random checks of latency_fifo against a queue-based model.
module tb_latency_fifo;

    localparam int DW    = 16;
    localparam int LW    = 5;
    localparam int DEPTH = 4;
    localparam int LMAX  = 31;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [LW-1:0] in_latency;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [LW-1:0] out_latency;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    int            exp_lat;

    latency_fifo #(.DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .in_latency  (in_latency),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_latency (out_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        int            sz;
        int            s;
        bit            do_push;
        bit            do_pop;
        logic [DW-1:0] d;
        int            ol;
        sz = q.size();
        chk("in_ready", in_ready, (sz != DEPTH));
        chk("out_valid", out_valid, (sz != 0));
        if (sz != 0) chk("out_data", out_data, q[0]);
        chk("in_latency", in_latency, exp_lat);
        do_push = in_valid && (sz != DEPTH);
        do_pop  = out_ready && (sz != 0);
        d  = in_data;
        ol = int'(out_latency);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
        s = q.size() + ol;
        exp_lat = (s > LMAX) ? LMAX : s;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 16'hBEEF;
        out_ready   = 1'b0;
        out_latency = 5'd3;
        exp_lat     = 0;

        // Reset holds everything clear even with in_valid and out_latency active.
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_latency", in_latency, 0);
        in_valid    = 1'b0;
        out_latency = 5'd0;
        rst_n       = 1'b1;
        cycle();
        chk("post_rst_empty", out_valid, 0);

        // Fill then drain.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i * 16'h0011);
            cycle();
        end
        chk("fill_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_out_valid", out_valid, 0);

        // Full with a simultaneous pop: the push is refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(16'h0100 + i);
            cycle();
        end
        in_data   = 16'h0ABC;
        out_ready = 1'b1;
        cycle();
        chk("full_pop_ready", in_ready, 1);
        chk("full_pop_head", out_data, 16'h0101);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Streaming 20 words through an empty buffer.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = DW'(i);
            cycle();
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        cycle();

        // Latency sum with three entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(16'h0200 + i);
            cycle();
        end
        in_valid    = 1'b0;
        out_latency = 5'd2;
        cycle();
        chk("lat_sum_5", in_latency, 5);
        out_latency = 5'd7;
        cycle();
        chk("lat_sum_10", in_latency, 10);

        // Saturation at full and at empty.
        in_valid = 1'b1;
        in_data  = 16'h0300;
        cycle();
        in_valid    = 1'b0;
        out_latency = 5'd30;
        cycle();
        chk("lat_sat_full", in_latency, 31);
        out_ready   = 1'b1;
        out_latency = 5'd31;
        for (int i = 0; i < 5; i++) cycle();
        chk("lat_sat_empty", in_latency, 31);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
            in_data     = DW'($urandom);
            out_latency = LW'($urandom_range(0, 31));
            cycle();
        end

        // Mid-operation reset clears outputs immediately.
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        out_latency = 5'd4;
        for (int i = 0; i < 2; i++) begin
            in_data = DW'(16'h0400 + i);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_latency", in_latency, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid    = 1'b0;
        out_latency = 5'd0;
        rst_n       = 1'b1;
        q.delete();
        exp_lat = 0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
